// File: rtl/bg_scene_scheduler.sv
// Background scene scheduler: picks the VGA background source per frame, blanking between scenes.
// Define SCHED_RANDOM_EN for LFSR-chosen auto/button advances (default build: sequential +1).
module bg_scene_scheduler #(
    parameter int unsigned DWELL_FRAMES = 180,
    parameter int unsigned BLANK_FRAMES = 4,
    parameter int unsigned CNT_W        = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [1:0]       mode_req,
    input  logic             auto_en,
    input  logic             next_btn,
    output logic [1:0]       bg_sel,
    output logic             blank,
    output logic             switch_pulse,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int unsigned BL_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
    localparam logic [BL_W-1:0] BLANK_LAST = BL_W'(BLANK_FRAMES);

    typedef enum logic [0:0] {StRun, StBlank} state_e;

    state_e          state;
    logic [DW_W-1:0] dwell;
    logic [BL_W-1:0] blank_cnt;
    logic [BL_W-1:0] blank_cnt_inc;
    logic [1:0]      target;
    logic [1:0]      adv_target;
    logic [1:0]      new_target;
    logic            btn_meta;
    logic            btn_sync;
    logic            btn_samp;
    logic            btn_deb;
    logic            btn_pend;
    logic            deb_next;
    logic            btn_rise;
    logic            go_change;

    // Only the synchroniser runs every cycle; everything else steps on frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= next_btn;
            btn_sync <= btn_meta;
        end
    end

`ifdef SCHED_RANDOM_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else if (frame_start) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Never pick the scene already on screen.
    always_comb begin
        adv_target = lfsr[1:0];
        if (lfsr[1:0] == bg_sel) adv_target = lfsr[1:0] + 2'd1;
    end
`else
    assign adv_target = bg_sel + 2'd1;
`endif

    // Debounced level flips only on two agreeing frame-rate samples.
    always_comb begin
        deb_next = btn_deb;
        if (btn_sync && btn_samp) begin
            deb_next = 1'b1;
        end else if (!btn_sync && !btn_samp) begin
            deb_next = 1'b0;
        end
        btn_rise = deb_next & ~btn_deb;
    end

    always_comb begin
        go_change  = 1'b0;
        new_target = target;
        if (state == StRun) begin
            if (auto_en) begin
                if (btn_pend || (dwell == DWELL_LAST)) begin
                    go_change  = 1'b1;
                    new_target = adv_target;
                end
            end else if (mode_req != bg_sel) begin
                go_change  = 1'b1;
                new_target = mode_req;
            end
        end
    end

    assign blank_cnt_inc = blank_cnt + BL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StRun;
            dwell        <= '0;
            blank_cnt    <= '0;
            target       <= 2'd0;
            btn_samp     <= 1'b0;
            btn_deb      <= 1'b0;
            btn_pend     <= 1'b0;
            bg_sel       <= 2'd0;
            blank        <= 1'b0;
            switch_pulse <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            switch_pulse <= 1'b0;
            if (frame_start) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                btn_samp  <= btn_sync;
                btn_deb   <= deb_next;
                unique case (state)
                    StRun: begin
                        if (!auto_en || go_change) begin
                            dwell <= '0;
                        end else begin
                            dwell <= dwell + DW_W'(1);
                        end
                        // Manual mode discards button presses outright.
                        btn_pend <= auto_en ? ((btn_pend & ~go_change) | btn_rise) : 1'b0;
                        if (go_change) begin
                            target <= new_target;
                            if (BLANK_FRAMES == 0) begin
                                bg_sel       <= new_target;
                                switch_pulse <= 1'b1;
                            end else begin
                                state     <= StBlank;
                                blank     <= 1'b1;
                                blank_cnt <= '0;
                            end
                        end
                    end
                    StBlank: begin
                        btn_pend  <= btn_pend | btn_rise;
                        blank_cnt <= blank_cnt_inc;
                        if (blank_cnt_inc == BLANK_LAST) begin
                            bg_sel       <= target;
                            blank        <= 1'b0;
                            switch_pulse <= 1'b1;
                            state        <= StRun;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bg_scene_scheduler.sv
// Bench for bg_scene_scheduler: three parameterisations share one stimulus and a frame-level model.
// Also builds with SCHED_RANDOM_EN defined; sequence-specific literal checks are then skipped.
module tb_bg_scene_scheduler;

    localparam int unsigned DW0 = 180;
    localparam int unsigned BF0 = 4;
    localparam int unsigned DW1 = 3;
    localparam int unsigned BF1 = 1;
    localparam int unsigned DW2 = 2;
    localparam int unsigned BF2 = 0;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic [1:0] mode_req;
    logic       auto_en;
    logic       next_btn;
    logic [1:0] bg_sel [3];
    logic       blank  [3];
    logic       sp     [3];
    logic [9:0] fc     [3];

    int n_cmp;
    int n_err;

    bg_scene_scheduler #(.DWELL_FRAMES(DW0), .BLANK_FRAMES(BF0), .CNT_W(10)) u_d0 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mode_req(mode_req),
        .auto_en(auto_en), .next_btn(next_btn), .bg_sel(bg_sel[0]), .blank(blank[0]),
        .switch_pulse(sp[0]), .frame_cnt(fc[0])
    );
    bg_scene_scheduler #(.DWELL_FRAMES(DW1), .BLANK_FRAMES(BF1), .CNT_W(10)) u_d1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mode_req(mode_req),
        .auto_en(auto_en), .next_btn(next_btn), .bg_sel(bg_sel[1]), .blank(blank[1]),
        .switch_pulse(sp[1]), .frame_cnt(fc[1])
    );
    bg_scene_scheduler #(.DWELL_FRAMES(DW2), .BLANK_FRAMES(BF2), .CNT_W(10)) u_d2 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mode_req(mode_req),
        .auto_en(auto_en), .next_btn(next_btn), .bg_sel(bg_sel[2]), .blank(blank[2]),
        .switch_pulse(sp[2]), .frame_cnt(fc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dwell_of(input int i);
        case (i)
            0: return int'(DW0);
            1: return int'(DW1);
            default: return int'(DW2);
        endcase
    endfunction

    function automatic int blank_of(input int i);
        case (i)
            0: return int'(BF0);
            1: return int'(BF1);
            default: return int'(BF2);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: scene, frames of blanking still to go, frames shown under auto.
    int         m_cnt;
    logic [1:0] m_bg    [3];
    logic [1:0] m_tgt   [3];
    int         m_left  [3];
    int         m_since [3];
    bit         m_pend  [3];
    bit         m_pulse [3];
    logic [1:0] nb_dly;
    bit         last_smp;
    bit         smp;
    bit         m_deb;
    bit         new_deb;
    bit         rise;
    int         run_len;
    logic [1:0] pk;
    bit         model_ok;
`ifdef SCHED_RANDOM_EN
    logic [7:0] m_lfsr;
`endif

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cnt    = 0;
            nb_dly   = 2'b00;
            last_smp = 1'b0;
            run_len  = 1;
            m_deb    = 1'b0;
`ifdef SCHED_RANDOM_EN
            m_lfsr   = 8'hA5;
`endif
            for (int i = 0; i < 3; i++) begin
                m_bg[i]    = 2'd0;
                m_tgt[i]   = 2'd0;
                m_left[i]  = 0;
                m_since[i] = 0;
                m_pend[i]  = 1'b0;
                m_pulse[i] = 1'b0;
            end
            model_ok = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) m_pulse[i] = 1'b0;
            if (frame_start) begin
                smp      = nb_dly[1];
                run_len  = (smp == last_smp) ? run_len + 1 : 1;
                last_smp = smp;
                new_deb  = (run_len >= 2) ? smp : m_deb;
                rise     = new_deb && !m_deb;
                m_deb    = new_deb;
                for (int i = 0; i < 3; i++) begin
                    if (m_left[i] > 0) begin
                        m_pend[i] = m_pend[i] | rise;
                        m_left[i] = m_left[i] - 1;
                        if (m_left[i] == 0) begin
                            m_bg[i]    = m_tgt[i];
                            m_pulse[i] = 1'b1;
                        end
                    end else if (auto_en) begin
                        if (m_pend[i] || (m_since[i] + 1 == dwell_of(i))) begin
`ifdef SCHED_RANDOM_EN
                            pk = m_lfsr[1:0];
                            if (pk == m_bg[i]) pk = pk + 2'd1;
`else
                            pk = m_bg[i] + 2'd1;
`endif
                            m_pend[i]  = rise;
                            m_since[i] = 0;
                            m_tgt[i]   = pk;
                            if (blank_of(i) == 0) begin
                                m_bg[i]    = pk;
                                m_pulse[i] = 1'b1;
                            end else begin
                                m_left[i] = blank_of(i);
                            end
                        end else begin
                            m_pend[i]  = m_pend[i] | rise;
                            m_since[i] = m_since[i] + 1;
                        end
                    end else begin
                        m_pend[i]  = 1'b0;
                        m_since[i] = 0;
                        if (mode_req != m_bg[i]) begin
                            m_tgt[i] = mode_req;
                            if (blank_of(i) == 0) begin
                                m_bg[i]    = mode_req;
                                m_pulse[i] = 1'b1;
                            end else begin
                                m_left[i] = blank_of(i);
                            end
                        end
                    end
                end
                m_cnt = (m_cnt + 1) % 1024;
`ifdef SCHED_RANDOM_EN
                m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
            end
            nb_dly = {nb_dly[0], next_btn};
        end
    end

    logic [1:0] prev_bg  [3];
    int         sp_count [3];

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("d%0d bg_sel", i), int'(bg_sel[i]), int'(m_bg[i]));
                chk($sformatf("d%0d blank", i), int'(blank[i]), (m_left[i] > 0) ? 1 : 0);
                chk($sformatf("d%0d switch_pulse", i), int'(sp[i]), int'(m_pulse[i]));
                chk($sformatf("d%0d frame_cnt", i), int'(fc[i]), m_cnt);
                if (sp[i]) begin
                    chk($sformatf("d%0d switch changes scene", i),
                        (bg_sel[i] != prev_bg[i]) ? 1 : 0, 1);
                    sp_count[i]++;
                end
                prev_bg[i] = bg_sel[i];
            end
        end
    end

    // Pulse frame_start for one cycle after a short gap; returns just after the capturing edge.
    task automatic frame();
        repeat (3) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int base;

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        mode_req    = 2'd0;
        auto_en     = 1'b0;
        next_btn    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle manual mode, request matches scene.
        frames(3);
        chk("t1 bg_sel", int'(bg_sel[0]), 0);
        chk("t1 blank", int'(blank[0]), 0);
        chk("t1 frame_cnt", int'(fc[0]), 3);
        #1;
        chk("t1 no switch_pulse", sp_count[0], 0);

        // Manual request 0 -> 2 with four frames of blank.
        mode_req = 2'd2;
        frame();
        chk("t2 blank entered", int'(blank[0]), 1);
        chk("t2 zero-blank switches at once", int'(bg_sel[2]), 2);
        chk("t2 zero-blank stays unblanked", int'(blank[2]), 0);
        frames(3);
        chk("t2 blank held", int'(blank[0]), 1);
        chk("t2 scene held", int'(bg_sel[0]), 0);
        frame();
        chk("t2 new scene", int'(bg_sel[0]), 2);
        chk("t2 blank released", int'(blank[0]), 0);
        chk("t2 switch_pulse", int'(sp[0]), 1);
        frame();
        #1;
        chk("t2 single switch", sp_count[0], 1);

        // Auto cycling with dwell 3, blank 1 on d1.
        mode_req = 2'd0;
        auto_en  = 1'b1;
        do_reset();
        base = sp_count[1];
        for (int k = 1; k <= 4; k++) begin
            frames(4);
`ifndef SCHED_RANDOM_EN
            chk($sformatf("t3 step %0d bg_sel", k), int'(bg_sel[1]), k % 4);
`endif
            chk($sformatf("t3 step %0d blank", k), int'(blank[1]), 0);
        end
        #1;
        chk("t3 switch count", sp_count[1] - base, 4);

        // Button advance in auto mode with long dwell.
        do_reset();
        frames(10);
        next_btn = 1'b1;
        frame();
        next_btn = 1'b0;
        frames(3);
        chk("t4 glitch no advance", int'(bg_sel[0]), 0);
        chk("t4 glitch no blank", int'(blank[0]), 0);
        next_btn = 1'b1;
        frames(3);
        next_btn = 1'b0;
        chk("t4 button blank", int'(blank[0]), 1);
        frames(4);
`ifndef SCHED_RANDOM_EN
        chk("t4 button scene", int'(bg_sel[0]), 1);
`endif
        chk("t4 button switch_pulse", int'(sp[0]), 1);
        frames(179);
        chk("t4 dwell restarted", int'(blank[0]), 0);
        frame();
        chk("t4 dwell expiry blanks", int'(blank[0]), 1);

        // Changes during blank are ignored; reset mid-blank.
        auto_en  = 1'b0;
        mode_req = 2'd1;
        do_reset();
        frame();
        chk("t5 blank toward 1", int'(blank[0]), 1);
        mode_req = 2'd2;
        auto_en  = 1'b1;
        frame();
        auto_en = 1'b0;
        frames(3);
        chk("t5 frozen target", int'(bg_sel[0]), 1);
        chk("t5 blank ended", int'(blank[0]), 0);
        frames(2);
        chk("t5 mid-blank", int'(blank[0]), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 reset bg_sel", int'(bg_sel[0]), 0);
        chk("t5 reset blank", int'(blank[0]), 0);
        chk("t5 reset frame_cnt", int'(fc[0]), 0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        mode_req = 2'd0;

        // Frame counter wrap, then a long auto run.
        frames(1023);
        chk("t6 frame_cnt max", int'(fc[0]), 1023);
        frame();
        chk("t6 frame_cnt wrap", int'(fc[0]), 0);
        auto_en = 1'b1;
        frames(130);
        #1;
        chk("t6 many switches", (sp_count[2] >= 64) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
